gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Parametrised sequential successor to the team's combinational 4-bit binary-to-Gray converter.
- Holds a WIDTH-bit binary count with enable, up/down direction and synchronous load.
- Presents the binary value and its Gray encoding from the same registered cycle, plus a one-cycle wrap pulse.
- Used as a pointer source for clock-domain-crossing FIFOs and rotary/position sequencing, where only one output bit may change per step.

Parameters:
- WIDTH, 4, counter and output width in bits; legal range 2 to 32.
- INIT, 0, binary value loaded on reset; must be below 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; the count steps once per clock while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  binary value captured on load.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray code of bin_out.
- wrap  output  1  one-cycle pulse on modulo wrap.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst is high:
  - bin_out = INIT.
  - gray_out = INIT ^ (INIT >> 1).
  - wrap = 0.
  - These values apply immediately, with no clock required, including when rst is asserted mid-count.
- Counting is modulo 2^WIDTH. All arithmetic is WIDTH bits wide and the carry is discarded.
- Gray relation: gray_out is computed from the next binary value and registered in the same edge as bin_out. The invariant gray_out == bin_out ^ (bin_out >> 1) therefore holds in every cycle after reset, with zero cycles of skew between the two outputs.
- Update priority on each rising edge with rst low:
  1. load = 1: bin_out <= load_val and wrap <= 0. en and up are ignored.
  2. Otherwise, en = 1 and up = 1: bin_out <= bin_out + 1.
  3. Otherwise, en = 1 and up = 0: bin_out <= bin_out - 1.
  4. Otherwise (en = 0): hold the value, wrap <= 0.
- Wrap flag:
  - wrap <= 1 for exactly the cycle following an up-step from all-ones to 0.
  - wrap <= 1 for exactly the cycle following a down-step from 0 to all-ones.
  - wrap is 0 in every other cycle.
  - A load of any value never asserts wrap.
- Single-bit property: every en-driven step, up or down, changes exactly one bit of gray_out. A load may change any number of bits.
- Direction change: a change of up takes effect on the same edge. There is no pipeline and no dead cycle.
- Latency: one clock from an input edge to the outputs for both count and load.
- No combinational path from any input to any output.
- Inputs are assumed synchronous to clk. No internal synchronisers.

Test Plan:
1. Reset and full up-count (WIDTH=4, INIT=0):
   - Stimulus: assert rst, then en=1, up=1 for 16 clocks.
   - Required: outputs are 0/0 while rst is high.
   - Required gray_out sequence: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000.
   - Required: wrap is high for exactly the one cycle in which bin_out returns to 0000.
2. Down-count wrap:
   - Stimulus: load_val=0001 with load=1, then en=1, up=0 for 3 clocks.
   - Required bin_out: 0001, 0000, 1111, 1110.
   - Required gray_out on the wrapped step: 1000.
   - Required: wrap is high only in the 1111 cycle.
3. Load priority:
   - Stimulus: load=1, en=1, up=1, load_val=1010 in the same cycle.
   - Required: bin_out=1010, gray_out=1111, wrap=0.
   - Stimulus: a load of 0000 while bin_out=1111.
   - Required: wrap stays 0.
4. Hold and direction change:
   - Stimulus: en=0 for 5 clocks at bin_out=0110.
   - Required: the value is unchanged throughout.
   - Stimulus: en=1 with up toggling every cycle.
   - Required bin_out alternates 0111, 0110, 0111.
5. Asynchronous reset mid-count (INIT=0101):
   - Stimulus: pulse rst between clock edges at bin_out=1100.
   - Required: bin_out=0101 and gray_out=0111 before the next edge; wrap=0.
6. Parametric sweep (WIDTH=8, random en/up/load for 10000 cycles):
   - Required: the Gray relation holds in every cycle.
   - Required: each en-driven step changes exactly one gray_out bit.
   - Required: bin_out matches a reference modulo-256 model.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down modulo-2^WIDTH counter presenting the binary count and its Gray code
// from the same register edge, plus a one-cycle wrap pulse on modulo rollover.
module gray_counter #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] GRAY_INIT = INIT ^ (INIT >> 1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    // Gray is derived from the next binary value so both outputs share one edge.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (up) begin
                bin_d  = bin_q + ONE;
                wrap_d = (bin_q == ALL_ONES);
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = (bin_q == ZERO);
            end
        end
        gray_d = bin2gray(bin_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= INIT;
            gray_q <= GRAY_INIT;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: directed sequences on two 4-bit instances and a
// randomized 8-bit sweep, all checked every cycle against an arithmetic model.
module tb_gray_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: WIDTH=4, INIT=0
    logic       a_rst, a_en, a_up, a_load, a_wrap;
    logic [3:0] a_lv, a_bin, a_gray;
    // Instance B: WIDTH=4, INIT=0101
    logic       b_rst, b_en, b_up, b_load, b_wrap;
    logic [3:0] b_lv, b_bin, b_gray;
    // Instance C: WIDTH=8, INIT=0x3C
    logic       c_rst, c_en, c_up, c_load, c_wrap;
    logic [7:0] c_lv, c_bin, c_gray;

    gray_counter #(.WIDTH(4), .INIT(4'd0)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load),
        .load_val(a_lv), .bin_out(a_bin), .gray_out(a_gray), .wrap(a_wrap));

    gray_counter #(.WIDTH(4), .INIT(4'd5)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load),
        .load_val(b_lv), .bin_out(b_bin), .gray_out(b_gray), .wrap(b_wrap));

    gray_counter #(.WIDTH(8), .INIT(8'h3C)) u_c (
        .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .load(c_load),
        .load_val(c_lv), .bin_out(c_bin), .gray_out(c_gray), .wrap(c_wrap));

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: modulo counting with load priority.
    function automatic int nxt(int cur, bit ld, int lv, bit en, bit up, int n);
        if (ld) return lv;
        if (!en) return cur;
        if (up) return (cur + 1) % n;
        return (cur + n - 1) % n;
    endfunction

    function automatic bit wr(int cur, bit ld, bit en, bit up, int n);
        return !ld && en && ((up && cur == n - 1) || (!up && cur == 0));
    endfunction

    function automatic int gray_of(int v);
        return v ^ (v >> 1);
    endfunction

    int ma, mb, mc;
    bit mwa, mwb, mwc;
    bit msa, msb, msc;

    always @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            ma <= 0; mwa <= 1'b0; msa <= 1'b0;
        end else begin
            ma  <= nxt(ma, a_load, int'(a_lv), a_en, a_up, 16);
            mwa <= wr(ma, a_load, a_en, a_up, 16);
            msa <= a_en && !a_load;
        end
    end

    always @(posedge clk or posedge b_rst) begin
        if (b_rst) begin
            mb <= 5; mwb <= 1'b0; msb <= 1'b0;
        end else begin
            mb  <= nxt(mb, b_load, int'(b_lv), b_en, b_up, 16);
            mwb <= wr(mb, b_load, b_en, b_up, 16);
            msb <= b_en && !b_load;
        end
    end

    always @(posedge clk or posedge c_rst) begin
        if (c_rst) begin
            mc <= 60; mwc <= 1'b0; msc <= 1'b0;
        end else begin
            mc  <= nxt(mc, c_load, int'(c_lv), c_en, c_up, 256);
            mwc <= wr(mc, c_load, c_en, c_up, 256);
            msc <= c_en && !c_load;
        end
    end

    // Per-cycle comparison against the models, away from the active edge.
    logic [3:0] pa, pb;
    logic [7:0] pc;
    always @(negedge clk) begin
        if (a_rst === 1'b0) begin
            check("a_bin", a_bin, ma);
            check("a_gray", a_gray, gray_of(ma));
            check("a_wrap", a_wrap, mwa);
            if (msa) check("a_onebit", $countones(a_gray ^ pa), 1);
        end
        if (b_rst === 1'b0) begin
            check("b_bin", b_bin, mb);
            check("b_gray", b_gray, gray_of(mb));
            check("b_wrap", b_wrap, mwb);
            if (msb) check("b_onebit", $countones(b_gray ^ pb), 1);
        end
        if (c_rst === 1'b0) begin
            check("c_bin", c_bin, mc);
            check("c_gray_rel", c_gray, c_bin ^ (c_bin >> 1));
            check("c_gray", c_gray, gray_of(mc));
            check("c_wrap", c_wrap, mwc);
            if (msc) check("c_onebit", $countones(c_gray ^ pc), 1);
        end
        pa = a_gray;
        pb = b_gray;
        pc = c_gray;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int gseq [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    task automatic run_a();
        a_rst = 1'b1; a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_lv = 4'd0;
        repeat (2) step();
        check("a_rst_bin", a_bin, 0);
        check("a_rst_gray", a_gray, 0);
        check("a_rst_wrap", a_wrap, 0);
        // Full up-count through the wrap
        a_rst = 1'b0; a_en = 1'b1; a_up = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("upseq_gray[%0d]", i), a_gray, gseq[i]);
            check($sformatf("upseq_wrap[%0d]", i), a_wrap, (i == 16) ? 1 : 0);
        end
        // Down-count through zero
        a_load = 1'b1; a_lv = 4'd1; a_en = 1'b0;
        step();
        check("dn_load_bin", a_bin, 1);
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b0;
        step();
        check("dn_bin0", a_bin, 0);
        check("dn_wrap0", a_wrap, 0);
        step();
        check("dn_bin15", a_bin, 15);
        check("dn_gray15", a_gray, 8);
        check("dn_wrap15", a_wrap, 1);
        step();
        check("dn_bin14", a_bin, 14);
        check("dn_wrap14", a_wrap, 0);
        // Load beats enable
        a_load = 1'b1; a_en = 1'b1; a_up = 1'b1; a_lv = 4'b1010;
        step();
        check("ld_pri_bin", a_bin, 10);
        check("ld_pri_gray", a_gray, 15);
        check("ld_pri_wrap", a_wrap, 0);
        a_lv = 4'b1111;
        step();
        check("ld_ff_bin", a_bin, 15);
        a_lv = 4'b0000;
        step();
        check("ld_00_bin", a_bin, 0);
        check("ld_00_wrap", a_wrap, 0);
        // Hold, then direction toggling
        a_lv = 4'd6; a_en = 1'b0;
        step();
        a_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hold_bin[%0d]", i), a_bin, 6);
        end
        a_en = 1'b1; a_up = 1'b1;
        step();
        check("tog_bin0", a_bin, 7);
        a_up = 1'b0;
        step();
        check("tog_bin1", a_bin, 6);
        a_up = 1'b1;
        step();
        check("tog_bin2", a_bin, 7);
        a_en = 1'b0;
    endtask

    task automatic run_b();
        b_rst = 1'b1; b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_lv = 4'd0;
        repeat (2) step();
        check("b_rst_bin", b_bin, 5);
        check("b_rst_gray", b_gray, 7);
        b_rst = 1'b0; b_load = 1'b1; b_lv = 4'b1011;
        step();
        b_load = 1'b1; b_lv = 4'b1111;
        step();
        b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
        step();
        check("b_wrap_pre", b_wrap, 1);
        b_load = 1'b1; b_lv = 4'b1011; b_en = 1'b1;
        step();
        b_load = 1'b0;
        step();
        check("b_pre_bin", b_bin, 12);
        b_en = 1'b0;
        // Reset pulse between edges
        #2;
        b_rst = 1'b1;
        #1;
        check("b_async_bin", b_bin, 5);
        check("b_async_gray", b_gray, 7);
        check("b_async_wrap", b_wrap, 0);
        b_rst = 1'b0;
        repeat (3) step();
        check("b_post_bin", b_bin, 5);
    endtask

    task automatic run_c();
        c_rst = 1'b1; c_en = 1'b0; c_up = 1'b0; c_load = 1'b0; c_lv = 8'd0;
        repeat (2) step();
        check("c_rst_bin", c_bin, 60);
        c_rst = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            int sel;
            c_load = ($urandom_range(0, 15) == 0);
            sel = $urandom_range(0, 3);
            c_lv = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : 8'($urandom);
            c_en = ($urandom_range(0, 3) != 0);
            c_up = 1'($urandom);
            step();
        end
        c_en = 1'b0; c_load = 1'b0;
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        fork
            begin run_a(); run_b(); end
            run_c();
        join
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
